// File: rtl/scan_dff_register.sv
// WIDTH-bit register with true/complement outputs, synchronous reset, capture
// enable and a mux-D scan shift path with a shift-cycle counter.
module scan_dff_register #(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}},
  parameter bit                 MSB_FIRST = 1'b1,
  parameter int                 CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic             scan_en,
  input  logic             scan_in,
  output logic             scan_out,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             shift_done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] q_next;
  logic [CNT_W-1:0] cnt_next;
  logic             done_next;

  // Shift-path data; a one-bit segment simply takes scan_in.
  generate
    if (WIDTH == 1) begin : g_single
      assign shifted  = scan_in;
      assign scan_out = q[0];
    end else if (MSB_FIRST) begin : g_msb_first
      assign shifted  = {q[WIDTH-2:0], scan_in};
      assign scan_out = q[WIDTH-1];
    end else begin : g_lsb_first
      assign shifted  = {scan_in, q[WIDTH-1:1]};
      assign scan_out = q[0];
    end
  endgenerate

  // Scan mode dominates capture; d is never looked at while shifting.
  always_comb begin
    q_next = q;
    if (scan_en) begin
      q_next = shifted;
    end else if (en) begin
      q_next = d;
    end
  end

  // Any non-shift edge restarts the count, so only unbroken runs of WIDTH
  // shifts raise shift_done.
  always_comb begin
    cnt_next  = '0;
    done_next = 1'b0;
    if (scan_en) begin
      if (shift_cnt == CNT_LAST) begin
        cnt_next  = '0;
        done_next = 1'b1;
      end else begin
        cnt_next  = shift_cnt + CNT_W'(1);
        done_next = 1'b0;
      end
    end
  end

  // q_n is its own flop bank loaded with the complement of q's next value.
  always_ff @(posedge clk) begin
    if (rst) begin
      q          <= RESET_VAL;
      q_n        <= ~RESET_VAL;
      shift_cnt  <= '0;
      shift_done <= 1'b0;
    end else begin
      q          <= q_next;
      q_n        <= ~q_next;
      shift_cnt  <= cnt_next;
      shift_done <= done_next;
    end
  end

endmodule

// File: tb/tb_scan_dff_register.sv
// Directed bench for scan_dff_register: an 8-bit MSB-first segment, a 4-bit
// LSB-first segment and a 1-bit segment, all on one clock.
module tb_scan_dff_register;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit, MSB_FIRST=1
  logic       rst8, en8, scan_en8, scan_in8, scan_out8, done8;
  logic [7:0] d8, q8, qn8;
  logic [3:0] cnt8;
  // 4-bit, MSB_FIRST=0
  logic       rst4, en4, scan_en4, scan_in4, scan_out4, done4;
  logic [3:0] d4, q4, qn4;
  logic [2:0] cnt4;
  // 1-bit
  logic       rst1, en1, scan_en1, scan_in1, scan_out1, done1;
  logic [0:0] d1, q1, qn1;
  logic [0:0] cnt1;

  scan_dff_register #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut8 (
    .clk(clk), .rst(rst8), .en(en8), .d(d8), .scan_en(scan_en8),
    .scan_in(scan_in8), .scan_out(scan_out8), .q(q8), .q_n(qn8),
    .shift_cnt(cnt8), .shift_done(done8)
  );

  scan_dff_register #(.WIDTH(4), .MSB_FIRST(1'b0)) u_dut4 (
    .clk(clk), .rst(rst4), .en(en4), .d(d4), .scan_en(scan_en4),
    .scan_in(scan_in4), .scan_out(scan_out4), .q(q4), .q_n(qn4),
    .shift_cnt(cnt4), .shift_done(done4)
  );

  scan_dff_register #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst1), .en(en1), .d(d1), .scan_en(scan_en1),
    .scan_in(scan_in1), .scan_out(scan_out1), .q(q1), .q_n(qn1),
    .shift_cnt(cnt1), .shift_done(done1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] sin_vec;
  logic [7:0] sout_vec;

  initial begin
    rst8 = 1'b1; en8 = 1'b0; scan_en8 = 1'b0; scan_in8 = 1'b0; d8 = '0;
    rst4 = 1'b1; en4 = 1'b0; scan_en4 = 1'b0; scan_in4 = 1'b0; d4 = '0;
    rst1 = 1'b1; en1 = 1'b0; scan_en1 = 1'b0; scan_in1 = 1'b0; d1 = '0;
    tick();
    rst8 = 1'b0; rst4 = 1'b0; rst1 = 1'b0;

    // Reset state
    check("rst_q",        32'(q8),        32'h00);
    check("rst_qn",       32'(qn8),       32'hFF);
    check("rst_cnt",      32'(cnt8),      32'd0);
    check("rst_done",     32'(done8),     32'd0);
    check("rst_scan_out", 32'(scan_out8), 32'd0);

    // Capture then hold
    en8 = 1'b1; d8 = 8'hA5;
    tick();
    check("cap_q",  32'(q8),  32'hA5);
    check("cap_qn", 32'(qn8), 32'h5A);
    en8 = 1'b0; d8 = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_q", 32'(q8), 32'hA5);
    end

    // Full 8-bit shift; element i of each vector belongs to edge i
    sin_vec  = 8'b1100_0011;
    sout_vec = 8'b1010_0101;
    for (int i = 0; i < 8; i++) exp_q.push_back({7'd0, sout_vec[7-i]});
    scan_en8 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      scan_in8 = sin_vec[7-i];
      #1;
      check("shift_scan_out", 32'(scan_out8), 32'(exp_q.pop_front()));
      tick();
      check("shift_done", 32'(done8), (i == 7) ? 32'd1 : 32'd0);
      check("shift_cnt",  32'(cnt8),  (i == 7) ? 32'd0 : 32'(i + 1));
    end
    check("shift_q",  32'(q8),  32'hC3);
    check("shift_qn", 32'(qn8), 32'h3C);
    scan_en8 = 1'b0;
    tick();
    check("done_one_cycle", 32'(done8), 32'd0);
    check("after_shift_hold_q", 32'(q8), 32'hC3);

    // Priority: shift beats capture
    en8 = 1'b1; d8 = 8'h81;
    tick();
    check("prio_setup_q", 32'(q8), 32'h81);
    scan_en8 = 1'b1; en8 = 1'b1; d8 = 8'hFF; scan_in8 = 1'b0;
    tick();
    check("prio_q",   32'(q8),   32'h02);
    check("prio_cnt", 32'(cnt8), 32'd1);
    check("prio_qn",  32'(qn8),  32'hFD);

    // Interrupt: clear, 5 shifts, one idle edge
    scan_en8 = 1'b0; en8 = 1'b0;
    tick();
    check("clr_cnt", 32'(cnt8), 32'd0);
    scan_en8 = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("int_cnt5", 32'(cnt8), 32'd5);
    scan_en8 = 1'b0;
    tick();
    check("int_cnt_clr", 32'(cnt8),  32'd0);
    check("int_no_done", 32'(done8), 32'd0);
    scan_en8 = 1'b1; scan_in8 = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("int_cnt3", 32'(cnt8), 32'd3);
    rst8 = 1'b1;
    tick();
    rst8 = 1'b0;
    check("midrst_q",    32'(q8),    32'h00);
    check("midrst_qn",   32'(qn8),   32'hFF);
    check("midrst_cnt",  32'(cnt8),  32'd0);
    check("midrst_done", 32'(done8), 32'd0);

    // Back-to-back 16 shifts: pulses after edges 8 and 16 only
    for (int i = 0; i < 16; i++) begin
      tick();
      check("b2b_done", 32'(done8), (i == 7 || i == 15) ? 32'd1 : 32'd0);
    end
    scan_en8 = 1'b0;
    tick();
    check("b2b_q_all_ones", 32'(q8), 32'hFF);

    // 4-bit LSB-first segment
    en4 = 1'b1; d4 = 4'b0001;
    tick();
    en4 = 1'b0;
    check("w4_cap_q", 32'(q4), 32'h1);
    sout_vec = 8'b0000_1000;
    for (int i = 0; i < 4; i++) exp_q.push_back({7'd0, sout_vec[3-i]});
    scan_en4 = 1'b1; scan_in4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("w4_scan_out", 32'(scan_out4), 32'(exp_q.pop_front()));
      tick();
      check("w4_done", 32'(done4), (i == 3) ? 32'd1 : 32'd0);
    end
    scan_en4 = 1'b0;
    check("w4_q",   32'(q4),   32'hF);
    check("w4_qn",  32'(qn4),  32'h0);
    check("w4_cnt", 32'(cnt4), 32'd0);
    tick();
    check("w4_done_clear", 32'(done4), 32'd0);

    // 1-bit segment: every shift completes the chain
    scan_en1 = 1'b1; scan_in1 = 1'b1;
    tick();
    check("w1_q1",    32'(q1),    32'd1);
    check("w1_qn1",   32'(qn1),   32'd0);
    check("w1_done1", 32'(done1), 32'd1);
    check("w1_cnt1",  32'(cnt1),  32'd0);
    scan_in1 = 1'b0;
    tick();
    check("w1_q2",    32'(q1),    32'd0);
    check("w1_done2", 32'(done1), 32'd1);
    scan_en1 = 1'b0; en1 = 1'b1; d1 = 1'b1;
    tick();
    check("w1_cap_q",  32'(q1),    32'd1);
    check("w1_done3",  32'(done1), 32'd0);
    check("w1_scanout", 32'(scan_out1), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
